scaler_linear_v: RTL

Vertical linear (bilinear-in-y) downscaler for the scaler2 pipeline. Sits directly downstream of the horizontal scaler and consumes its `do_o/de_o/hs_o/vs_o` stream unchanged. Keeps one previous input line in a line buffer and blends it with the current line to produce each output line. Output lines are emitted in step with the input line that completes them; there is no output-side timing generator.

---
 rtl/scaler2_pkg.sv | 21 ++
 rtl/scaler_linear_v_if.sv | 11 +
 rtl/scaler_v_linebuf.sv | 18 +
 rtl/scaler_linear_v.sv | 131 +++++++++++++
 4 files changed

// File: rtl/scaler2_pkg.sv
// Shared scaler2 constants and types for the vertical scaler.
// Rounding constant depends on SCALER_V_ROUND_EN (defined: round half up, else truncate).
package scaler2_pkg;
  localparam int PIXEL_STEP  = 4096;
  localparam int PIXEL_WIDTH = 12;
  localparam int COE_WIDTH   = 10;
  localparam int MAX_LINE    = 4096;
  localparam int CNT_W       = 24;
  localparam int STEP_SHIFT  = $clog2(PIXEL_STEP);
  localparam int LB_AW       = $clog2(MAX_LINE);
  localparam int X_W         = LB_AW + 1;
  localparam int COE_UNITY   = 1 << (COE_WIDTH - 1);
`ifdef SCALER_V_ROUND_EN
  localparam int V_ROUND     = 1 << (COE_WIDTH - 2);
`else
  localparam int V_ROUND     = 0;
`endif

  typedef logic [PIXEL_WIDTH-1:0] pix_t;
  typedef logic [COE_WIDTH-1:0]   coe_t;
endpackage

// File: rtl/scaler_linear_v_if.sv
// Pixel stream bundle (data / valid / line start / frame start) used on both
// sides of the vertical scaler.
interface scaler_linear_v_if;
  scaler2_pkg::pix_t data;
  logic              de;
  logic              hs;
  logic              vs;

  modport master (output data, de, hs, vs);
  modport slave  (input  data, de, hs, vs);
endinterface

// File: rtl/scaler_v_linebuf.sv
// One-line pixel store: simple dual-port RAM, registered read, read-before-write.
module scaler_v_linebuf
  import scaler2_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LB_AW-1:0] waddr,
  input  pix_t             wdata,
  input  logic [LB_AW-1:0] raddr,
  output pix_t             rdata
);
  pix_t mem [MAX_LINE];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/scaler_linear_v.sv
// Vertical bilinear downscaler: blends the buffered previous line with the current one.
// SCALER_V_ROUND_EN selects round-half-up instead of truncation (see scaler2_pkg).
module scaler_linear_v
  import scaler2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       v_scale_step,
  scaler_linear_v_if.slave  vin,
  scaler_linear_v_if.master vout
);
  localparam int PROD_W = PIXEL_WIDTH + COE_WIDTH;
  localparam int SUM_W  = PROD_W + 1;
  localparam int HI_W   = PIXEL_WIDTH + 1;
  localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(PIXEL_STEP);
  localparam logic [X_W-1:0]   X_LIMIT  = X_W'(MAX_LINE);
  localparam coe_t             COE_ONE  = coe_t'(COE_UNITY);
  localparam logic [SUM_W-1:0] ROUND_C  = SUM_W'(V_ROUND);

  logic [CNT_W-1:0] cnt_i, cnt_o, step;
  logic             armed, line_emit;
  coe_t             line_c_prev;
  logic [X_W-1:0]   x_cnt;

  logic             line_start, frame_start, emit_now, pix_emit, ovr_now;
  logic [CNT_W-1:0] cnt_i_nxt, cnt_o_base, step_nxt, frac;
  logic [CNT_W+COE_WIDTH-2:0] frac_sh;
  coe_t             c_prev_now, pix_c_prev;
  logic [X_W-1:0]   x_cur;

  always_comb begin
    line_start  = vin.de & vin.hs;
    frame_start = line_start & vin.vs;
    step_nxt    = step;
    cnt_i_nxt   = cnt_i;
    cnt_o_base  = cnt_o;
    if (frame_start) begin
      step_nxt   = (CNT_W'(v_scale_step) < STEP_ONE) ? STEP_ONE : CNT_W'(v_scale_step);
      cnt_i_nxt  = '0;
      cnt_o_base = '0;
    end else if (line_start) begin
      cnt_i_nxt = cnt_i + STEP_ONE;
    end
    // frac is below one line step whenever the line emits
    emit_now   = (armed | frame_start) & (cnt_i_nxt >= cnt_o_base);
    frac       = cnt_i_nxt - cnt_o_base;
    frac_sh    = {frac, {(COE_WIDTH-1){1'b0}}};
    c_prev_now = coe_t'(frac_sh >> STEP_SHIFT);
    pix_emit   = line_start ? emit_now : line_emit;
    pix_c_prev = line_start ? c_prev_now : line_c_prev;
    x_cur      = line_start ? '0 : x_cnt;
    ovr_now    = (x_cur >= X_LIMIT);
  end

  pix_t             d0, cur1, rdata, prev1, do_r;
  logic [LB_AW-1:0] a0;
  logic             we0, ovr0, ovr1;
  logic             v0, h0, f0, v1, h1, f1, v2, h2, f2, v3, h3, f3;
  logic             de_r, hs_r, vs_r;
  coe_t             c0, c1, c_cur1;
  logic [PROD_W-1:0] p_cur, p_prev;
  logic [HI_W-1:0]  sum_hi;

  assign prev1  = ovr1 ? cur1 : rdata;
  assign c_cur1 = COE_ONE - c1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_i       <= '0;
      cnt_o       <= '0;
      step        <= STEP_ONE;
      armed       <= 1'b0;
      line_emit   <= 1'b0;
      line_c_prev <= '0;
      x_cnt       <= '0;
      we0         <= 1'b0;
      {v0, h0, f0, v1, h1, f1, v2, h2, f2, v3, h3, f3} <= '0;
      {de_r, hs_r, vs_r} <= '0;
      do_r        <= '0;
    end else begin
      if (line_start) begin
        cnt_i       <= cnt_i_nxt;
        cnt_o       <= emit_now ? cnt_o_base + step_nxt : cnt_o_base;
        line_emit   <= emit_now;
        line_c_prev <= c_prev_now;
      end
      if (frame_start) begin
        step  <= step_nxt;
        armed <= 1'b1;
      end
      if (vin.de) x_cnt <= x_cur + X_W'(1);
      // every input line is stored, emitted or not
      we0 <= vin.de & ~ovr_now;
      v0  <= vin.de & pix_emit;
      h0  <= line_start & emit_now;
      f0  <= frame_start & emit_now;
      {v1, h1, f1} <= {v0, h0, f0};
      {v2, h2, f2} <= {v1, h1, f1};
      {v3, h3, f3} <= {v2, h2, f2};
      {de_r, hs_r, vs_r} <= {v3, h3, f3};
      do_r <= sum_hi[PIXEL_WIDTH] ? '1 : sum_hi[PIXEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    d0     <= vin.data;
    a0     <= x_cur[LB_AW-1:0];
    ovr0   <= ovr_now;
    c0     <= pix_c_prev;
    cur1   <= d0;
    ovr1   <= ovr0;
    c1     <= c0;
    p_cur  <= {{PIXEL_WIDTH{1'b0}}, c_cur1} * {{COE_WIDTH{1'b0}}, cur1};
    p_prev <= {{PIXEL_WIDTH{1'b0}}, c1} * {{COE_WIDTH{1'b0}}, prev1};
    sum_hi <= HI_W'((SUM_W'(p_cur) + SUM_W'(p_prev) + ROUND_C) >> (COE_WIDTH - 1));
  end

  scaler_v_linebuf u_linebuf (
    .clk   (clk),
    .we    (we0),
    .waddr (a0),
    .wdata (d0),
    .raddr (a0),
    .rdata (rdata)
  );

  assign vout.data = do_r;
  assign vout.de   = de_r;
  assign vout.hs   = hs_r;
  assign vout.vs   = vs_r;
endmodule
